// File: rtl/gray_pkg.sv
// Shared types and pure Gray/binary helpers for the Gray-code receive checker.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    EMPTY,
    ACQUIRE,
    LOCKED
  } rx_state_e;

  // Mask covering the low w bits of a GRAY_MAX_W-bit word.
  function automatic logic [GRAY_MAX_W-1:0] width_mask(input int unsigned w);
    if (w >= GRAY_MAX_W) return '1;
    return (GRAY_MAX_W'(1) << w) - GRAY_MAX_W'(1);
  endfunction

  // Binary to Gray, truncated to w bits so callers get mod-2^w wrap for free.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b,
                                                    input int unsigned w);
    logic [GRAY_MAX_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Gray to binary; bits above w are forced to zero so they cannot leak in.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                    input int unsigned w);
    logic [GRAY_MAX_W-1:0] gm;
    logic [GRAY_MAX_W-1:0] b;
    gm = g & width_mask(w);
    b = '0;
    b[GRAY_MAX_W-1] = gm[GRAY_MAX_W-1];
    for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ gm[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder, MSB-first XOR chain.
module gray_to_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    logic [WIDTH-1:0] acc;
    acc = '0;
    acc[WIDTH-1] = gray[WIDTH-1];
    for (int unsigned i = WIDTH - 1; i > 0; i--) begin
      acc[i-1] = acc[i] ^ gray[i-1];
    end
    bin = acc;
  end

endmodule

// File: rtl/gray_rx_checker.sv
// Gray-code receive checker: decodes each sample, tracks sequence lock and
// counts successor violations seen while locked.
module gray_rx_checker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned LOCK_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gray_valid,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             seq_error,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(LOCK_N + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0] bin_out_q, bin_out_d;
  logic             bin_valid_q, bin_valid_d;
  logic             locked_q, locked_d;
  logic             seq_error_q, seq_error_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0] bin_dec;
  logic [WIDTH-1:0] expected;
  logic             err_hit;

  gray_to_bin #(.WIDTH(WIDTH)) u_dec (
    .gray (gray_in),
    .bin  (bin_dec)
  );

  // Expected successor of the reference; masking inside bin2gray gives the wrap.
  always_comb begin
    expected = WIDTH'(bin2gray(gray2bin(GRAY_MAX_W'(ref_q), WIDTH) + GRAY_MAX_W'(1), WIDTH));
  end

  // Next-state: every valid sample becomes the new reference; the FSM only
  // decides match counting, lock and error reporting.
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    match_cnt_d = match_cnt_q;
    bin_out_d   = bin_out_q;
    bin_valid_d = gray_valid;
    seq_error_d = 1'b0;
    err_hit     = 1'b0;

    if (gray_valid) begin
      bin_out_d = bin_dec;
      ref_d     = gray_in;
      unique case (state_q)
        EMPTY: begin
          match_cnt_d = '0;
          state_d     = ACQUIRE;
        end
        ACQUIRE: begin
          if (gray_in == expected) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
            if (match_cnt_d == CNT_W'(LOCK_N)) state_d = LOCKED;
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (gray_in != expected) begin
            seq_error_d = 1'b1;
            err_hit     = 1'b1;
            match_cnt_d = '0;
            state_d     = ACQUIRE;
          end
        end
        default: begin
          match_cnt_d = '0;
          state_d     = EMPTY;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);

    if (clear_err) begin
      err_count_d = '0;
    end else if (err_hit && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // All checker state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      ref_q       <= '0;
      match_cnt_q <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      seq_error_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      match_cnt_q <= match_cnt_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      locked_q    <= locked_d;
      seq_error_q <= seq_error_d;
      err_count_q <= err_count_d;
    end
  end

  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign locked    = locked_q;
  assign seq_error = seq_error_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_rx_checker.sv
// Scoreboard bench for gray_rx_checker: stimulus pushes expected responses,
// a negedge monitor pops and compares on every bin_valid.
module tb_gray_rx_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       gray_valid;
  logic [3:0] gray_in;
  logic       clear_err;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       locked;
  logic       seq_error;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  gray_rx_checker #(.WIDTH(4), .ERR_W(8), .LOCK_N(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .gray_in    (gray_in),
    .clear_err  (clear_err),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .locked     (locked),
    .seq_error  (seq_error),
    .err_count  (err_count)
  );

  typedef struct packed {
    logic [3:0] bin;
    logic       lk;
    logic       se;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   tests  = 0;
  int   fails  = 0;
  int   pushed = 0;
  int   popped = 0;
  int   cur;
  int   ec;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] g_of(input int b);
    logic [3:0] t;
    t = 4'(b);
    return t ^ (t >> 1);
  endfunction

  // Drive one valid sample and record what the DUT must report for it.
  task automatic send(input logic [3:0] g, input logic [3:0] eb, input logic elk,
                      input logic ese, input logic [7:0] eec, input logic clr = 1'b0);
    exp_t e;
    gray_in    = g;
    gray_valid = 1'b1;
    clear_err  = clr;
    e.bin = eb; e.lk = elk; e.se = ese; e.ec = eec;
    q.push_back(e);
    pushed++;
    @(posedge clk);
    #1;
    gray_valid = 1'b0;
    clear_err  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare against the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!reset && bin_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got bin_valid=1 expected no pending sample");
      end else begin
        e_mon = q.pop_front();
        popped++;
        check("bin_out",   32'(bin_out),   32'(e_mon.bin));
        check("locked",    32'(locked),    32'(e_mon.lk));
        check("seq_error", 32'(seq_error), 32'(e_mon.se));
        check("err_count", 32'(err_count), 32'(e_mon.ec));
      end
    end else if (!reset && seq_error) begin
      tests++;
      fails++;
      $display("FAIL seq_error_stray: got 1 expected 0 without bin_valid");
    end
  end

  initial begin
    int w;
    reset      = 1'b1;
    gray_valid = 1'b0;
    gray_in    = '0;
    clear_err  = 1'b0;
    #12;
    check("rst_bin_out",   32'(bin_out),   32'd0);
    check("rst_bin_valid", 32'(bin_valid), 32'd0);
    check("rst_locked",    32'(locked),    32'd0);
    check("rst_seq_error", 32'(seq_error), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Acquire: lock appears with the third consecutive code.
    send(4'b0000, 4'd0, 1'b0, 1'b0, 8'd0);
    send(4'b0001, 4'd1, 1'b0, 1'b0, 8'd0);
    send(4'b0011, 4'd2, 1'b1, 1'b0, 8'd0);
    send(4'b0010, 4'd3, 1'b1, 1'b0, 8'd0);

    // Finish this cycle and run two full cycles, crossing 1000 -> 0000.
    for (int b = 4; b < 16; b++) send(g_of(b), 4'(b), 1'b1, 1'b0, 8'd0);
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 16; b++) send(g_of(b), 4'(b), 1'b1, 1'b0, 8'd0);

    // Walk to 0110, inject 0100, relock on 1100, 1101.
    for (int b = 0; b < 5; b++) send(g_of(b), 4'(b), 1'b1, 1'b0, 8'd0);
    send(4'b0100, 4'd7, 1'b0, 1'b1, 8'd1);
    send(4'b1100, 4'd8, 1'b0, 1'b0, 8'd1);
    send(4'b1101, 4'd9, 1'b1, 1'b0, 8'd1);
    cur = 9;
    ec  = 1;

    // Valid gaps of 0-5 cycles are not errors.
    for (int n = 0; n < 20; n++) begin
      idle($urandom_range(0, 5));
      cur = (cur + 1) % 16;
      send(g_of(cur), 4'(cur), 1'b1, 1'b0, 8'(ec));
    end

    // 259 repeated-code violations with a relock after each; count saturates.
    for (int k = 0; k < 259; k++) begin
      ec = (ec == 255) ? 255 : ec + 1;
      send(g_of(cur), 4'(cur), 1'b0, 1'b1, 8'(ec));
      cur = (cur + 1) % 16;
      send(g_of(cur), 4'(cur), 1'b0, 1'b0, 8'(ec));
      cur = (cur + 1) % 16;
      send(g_of(cur), 4'(cur), 1'b1, 1'b0, 8'(ec));
    end
    idle(1);
    check("err_saturated", 32'(err_count), 32'd255);

    // Clear coincident with a violation: clear wins, pulse still seen.
    send(g_of(cur), 4'(cur), 1'b0, 1'b1, 8'd0, 1'b1);
    cur = (cur + 1) % 16;
    send(g_of(cur), 4'(cur), 1'b0, 1'b0, 8'd0);
    cur = (cur + 1) % 16;
    send(g_of(cur), 4'(cur), 1'b1, 1'b0, 8'd0);
    if (cur == 0) begin
      cur = 1;
      send(g_of(cur), 4'(cur), 1'b1, 1'b0, 8'd0);
    end
    idle(2);

    // Mid-stream reset clears lock and bin_out without waiting for a clock.
    check("pre_reset_locked", 32'(locked), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_locked",    32'(locked),    32'd0);
    check("async_bin_out",   32'(bin_out),   32'd0);
    check("async_bin_valid", 32'(bin_valid), 32'd0);
    #10;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send(4'b0000, 4'd0, 1'b0, 1'b0, 8'd0);
    send(4'b0001, 4'd1, 1'b0, 1'b0, 8'd0);
    send(4'b0011, 4'd2, 1'b1, 1'b0, 8'd0);

    w = 0;
    while (q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #6;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    check("bin_valid_count",    32'(popped),   32'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_rx_checker.md
GRAY_RX_CHECKER -- requirements
Module: gray_rx_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4: Gray code width in bits.
REQ-002 SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-003 SHALL have parameter LOCK_N, default 2: number of consecutive correct successors needed to reach lock (LOCK_N >= 1).
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port gray_valid, input, 1 bit: gray_in is sampled this cycle.
REQ-007 SHALL have port gray_in, input, WIDTH bits: received Gray code word.
REQ-008 SHALL have port clear_err, input, 1 bit: synchronous clear of err_count.
REQ-009 SHALL have port bin_out, output, WIDTH bits: registered binary decode of the last sample.
REQ-010 SHALL have port bin_valid, output, 1 bit: one-cycle pulse when bin_out updates.
REQ-011 SHALL have port locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-012 SHALL have port seq_error, output, 1 bit: one-cycle pulse on a sequence violation while locked.
REQ-013 SHALL have port err_count, output, ERR_W bits: saturating count of sequence violations.

Function
REQ-014 SHALL decode as follows: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] XOR g[i] for i < WIDTH-1.
REQ-015 SHALL register bin_out and pulse bin_valid exactly 1 cycle after each cycle in which gray_valid=1; bin_out SHALL hold its value when gray_valid=0.
REQ-016 SHALL compute the expected next code as bin2gray((bin_prev + 1) mod 2^WIDTH), where bin2gray(b) = b XOR (b >> 1). Wrap-around 1000 -> 0000 (WIDTH=4) SHALL be accepted as correct.
REQ-017 SHALL implement an FSM with states EMPTY, ACQUIRE and LOCKED.
REQ-018 In EMPTY, the first valid sample SHALL be stored as the reference, set match_cnt=0 and move the FSM to ACQUIRE.
REQ-019 In ACQUIRE, a valid sample equal to the expected code SHALL increment match_cnt; on reaching LOCK_N the FSM SHALL move to LOCKED.
REQ-020 In ACQUIRE, a valid sample not equal to the expected code SHALL become the new reference and clear match_cnt to 0, with no seq_error and no count.
REQ-021 In LOCKED, a valid sample equal to the expected code SHALL stay in LOCKED.
REQ-022 In LOCKED, a valid sample not equal to the expected code SHALL pulse seq_error and increment err_count, become the new reference, clear match_cnt to 0, and move the FSM to ACQUIRE.
REQ-023 A repeated sample (equal to the previous code) SHALL be treated as a mismatch.
REQ-024 Every valid sample SHALL update the reference, regardless of whether it matched.
REQ-025 locked and seq_error SHALL both be registered, updating 1 cycle after the sample, aligned with bin_valid.
REQ-026 err_count SHALL saturate at 2^ERR_W-1 and SHALL NOT wrap.
REQ-027 clear_err SHALL zero err_count on the next edge; if clear_err coincides with an error, clear SHALL take priority (err_count=0) while seq_error still pulses.
REQ-028 gray_valid=0 cycles SHALL NOT change the FSM state, the reference or match_cnt; gaps are not errors.

Reset
REQ-029 Reset SHALL force state=EMPTY, match_cnt=0, reference=0, bin_out=0, bin_valid=0, locked=0, seq_error=0 and err_count=0.
REQ-030 Reset asserted mid-sequence SHALL discard lock immediately (locked=0 asynchronously); after release, reacquisition SHALL start from EMPTY.

Structure
REQ-031 Package gray_pkg SHALL hold the FSM state typedef (EMPTY/ACQUIRE/LOCKED) and the pure functions bin2gray and gray2bin, parameterised by width.
REQ-032 A combinational sub-module gray_to_bin (WIDTH-parameterised) SHALL perform the decode; the FSM, counters and registers SHALL reside in gray_rx_checker.
REQ-033 No memories; all state SHALL be flops.

Verification
REQ-034 Reset, then feed 0000,0001,0011,0010 on consecutive cycles -> bin_out 0,1,2,3; locked=1 in the cycle after 0011 (LOCK_N=2); seq_error never pulses.
REQ-035 Once locked, feed the full 16-code cycle twice, including 1000->0000 -> locked stays 1, err_count=0, and bin_out steps 0..15 then 0..15.
REQ-036 Once locked at code 0110, inject 0100 instead of 0111 -> one seq_error pulse, err_count=1, locked=0, then relock after 0101? no: after 1100,1101 (successors of 0100) -> locked=1.
REQ-037 Force 2^ERR_W+3 violations (relocking between each) -> err_count saturates at 255 (ERR_W=8); then clear_err coinciding with a violation -> err_count=0 and seq_error=1.
REQ-038 Locked sequence with random gray_valid gaps of 0-5 cycles -> no errors and bin_valid count equals the number of samples; assert reset mid-stream -> locked=0 and bin_out=0 immediately, reacquisition after release.
